inv_shiftrows_stream: RTL and testbench
=======================================

// Module: inv_shiftrows_stream
// PURPOSE
//  Byte-serial AES InvShiftRows for the decryption datapath; counterpart of the encrypt-side
//  ShiftRows stage. Accepts 16-byte states column-major (byte k = row k%4, col k/4) and emits
//  them in the same order with row r cyclically shifted right by r columns.
//  Ping-pong 2x16-byte buffer: one bank fills while the other drains; valid/ready on both sides.
// PARAMETERS
//  DATA_W     8  byte width; only 8 is supported, exists for lint/bench reuse
//  ZERO_IDLE  1  1: out_byte is forced to 0 while out_valid=0; 0: out_byte is don't-care
// PORTS
//  clock      in   1       single clock, all state on posedge
//  reset_n    in   1       synchronous reset, active-low
//  in_byte    in   DATA_W  state byte, column-major order
//  in_valid   in   1       in_byte is valid
//  in_ready   out  1       block accepts in_byte this cycle
//  out_byte   out  DATA_W  permuted state byte
//  out_valid  out  1       out_byte is valid
//  out_ready  in   1       downstream accepts out_byte
//  out_last   out  1       high with out_valid on byte 15 of a block
// BEHAVIOUR
//  - Reset: sampled on posedge while reset_n=0. Clears wr_cnt, rd_cnt, wr_bank, rd_bank, and full[1:0].
//    After reset: out_valid=0, out_last=0, out_byte=0, in_ready=1. Buffer contents are not cleared.
//  - Reset mid-block discards all partial and full blocks. No byte from before the reset ever appears.
//  - Write side: accept = in_valid & in_ready, where in_ready = !full[wr_bank].
//    On accept: mem[wr_bank][wr_cnt] <= in_byte and wr_cnt++.
//    On the accept with wr_cnt==15: set full[wr_bank], toggle wr_bank, wr_cnt <= 0.
//  - Read side: out_valid = full[rd_bank].
//    out_byte = mem[rd_bank][INV_SR_IDX[rd_cnt]], combinational from the registered bank.
//    out_last = out_valid & (rd_cnt==15).
//    On out_valid & out_ready: rd_cnt++. At rd_cnt==15: clear full[rd_bank], toggle rd_bank, rd_cnt <= 0.
//  - Permutation: out k=4c+r takes in 4*((c-r)&3)+r.
//    INV_SR_IDX = {0,13,10,7, 4,1,14,11, 8,5,2,15, 12,9,6,3}.
//  - Latency: first out_valid is the cycle after the posedge that accepts input byte 15.
//  - Throughput: 1 byte/clk sustained with in_valid=out_ready=1 and no bubbles between blocks.
//  - Simultaneous events: a set and a clear of full[] in one cycle always target different banks,
//    so both apply. A write to the draining bank is impossible because in_ready gates it.
//  - Full: both banks full -> in_ready=0 until the read bank's last byte is taken.
//    The write that frees a bank completes the same edge, so in_ready rises the following cycle.
//  - Empty: out_valid=0, and out_byte=0 when ZERO_IDLE=1. out_ready is ignored.
//  - Counters are 4-bit and wrap 15->0 only via the bank-switch rule above. Pointers are 1-bit.
//  - in_valid gaps are allowed: wr_cnt holds. out_ready stalls are allowed: out_byte and out_last hold.
// STRUCTURE
//  - aes_pkg (shared): AES_BLOCK_BYTES=16, localparam INV_SR_IDX table, and functions
//    sr_idx(k) / inv_sr_idx(k) returning 4-bit source indices.
//  - The encrypt-side stage is migrated to sr_idx so both directions share one definition.
//  - Single sub-module: aes_byte_bank (16x8 register file, 1 write port, 1 async read port),
//    instantiated twice and selected by wr_bank/rd_bank.
//  - FSM-free: control is counters plus full flags. No latches; all regs in one clocked always.
// TESTING
//  1. Reset, then feed 00..0F back-to-back with out_ready=1
//     -> out 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03; out_last on 03.
//  2. Round trip: bytes through the encrypt ShiftRows model, then this block, over 100 random blocks
//     -> output == original input. FIPS-197 App.B round-1 state also checks.
//  3. Backpressure: 3 blocks streamed, out_ready=0 -> in_ready drops after byte 31 (two banks full);
//     raise out_ready -> block 1 drains in order, in_ready returns the cycle after its out_last.
//  4. Gaps: random in_valid/out_ready at 50% -> identical data to test 1, no drops, no duplicates.
//  5. Reset mid-operation: reset_n low for 1 clk after 9 input bytes and one full bank
//     -> out_valid=0, out_byte=0, in_ready=1 next cycle; new block 10..1F emits 10,1D,1A,...,13 only.
//  6. Steady state: 8 blocks with in_valid=out_ready=1
//     -> out_valid continuous from cycle 17 to 144, no idle cycle between blocks.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared AES byte-ordering definitions: block size and the ShiftRows /
// InvShiftRows source-index maps for column-major state bytes (k = 4*col + row).
package aes_pkg;

  localparam int AES_BLOCK_BYTES = 16;

  // Output byte k of InvShiftRows takes input byte INV_SR_IDX[k].
  localparam logic [3:0] INV_SR_IDX [AES_BLOCK_BYTES] = '{
    4'd0,  4'd13, 4'd10, 4'd7,
    4'd4,  4'd1,  4'd14, 4'd11,
    4'd8,  4'd5,  4'd2,  4'd15,
    4'd12, 4'd9,  4'd6,  4'd3
  };

  // Encrypt direction: out k = 4c+r takes in 4*((c+r)&3)+r; the 2-bit add wraps mod 4.
  function automatic logic [3:0] sr_idx(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    r = k[1:0];
    c = k[3:2];
    return {2'(c + r), r};
  endfunction

  function automatic logic [3:0] inv_sr_idx(input logic [3:0] k);
    return INV_SR_IDX[k];
  endfunction

endpackage

// File: rtl/aes_byte_bank.sv
// 16-entry byte register file: one synchronous write port, one asynchronous read port.
module aes_byte_bank
  import aes_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [3:0]        wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [3:0]        rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [AES_BLOCK_BYTES];

  // NOTE: storage is deliberately not reset; the full flags in the parent gate
  // every read, so stale contents are never observable.
  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/inv_shiftrows_stream.sv
// Byte-serial AES InvShiftRows: ping-pong pair of 16-byte banks, one filling in
// arrival order while the other drains through the inverse row-shift index map.
module inv_shiftrows_stream
  import aes_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit ZERO_IDLE = 1'b1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] in_byte,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_byte,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last
);

  logic [3:0]        wr_cnt;
  logic [3:0]        rd_cnt;
  logic              wr_bank;
  logic              rd_bank;
  logic [1:0]        full;
  logic              accept;
  logic              take;
  logic [3:0]        rd_addr;
  logic [DATA_W-1:0] bank_data [2];

  assign in_ready  = !full[wr_bank];
  assign accept    = in_valid && in_ready;
  assign out_valid = full[rd_bank];
  assign take      = out_valid && out_ready;
  assign out_last  = out_valid && (rd_cnt == 4'd15);
  assign rd_addr   = inv_sr_idx(rd_cnt);

  for (genvar b = 0; b < 2; b++) begin : g_bank
    aes_byte_bank #(.DATA_W(DATA_W)) u_bank (
      .clock   (clock),
      .wr_en   (accept && (wr_bank == 1'(b))),
      .wr_addr (wr_cnt),
      .wr_data (in_byte),
      .rd_addr (rd_addr),
      .rd_data (bank_data[b])
    );
  end

  always_comb begin
    out_byte = bank_data[rd_bank];
    if (ZERO_IDLE && !out_valid) out_byte = '0;
  end

  // NOTE: non-blocking updates let the write side set one full bit and the read
  // side clear the other on the same edge; in_ready guarantees they never collide.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      wr_bank <= 1'b0;
      rd_bank <= 1'b0;
      full    <= '0;
    end else begin
      if (accept) begin
        if (wr_cnt == 4'd15) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= !wr_bank;
          wr_cnt        <= '0;
        end else begin
          wr_cnt <= wr_cnt + 4'd1;
        end
      end
      if (take) begin
        if (rd_cnt == 4'd15) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= !rd_bank;
          rd_cnt        <= '0;
        end else begin
          rd_cnt <= rd_cnt + 4'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_inv_shiftrows_stream.sv
// Scoreboard bench for inv_shiftrows_stream: expected bytes are queued when a
// block is scheduled and compared as the DUT hands each byte downstream.
module tb_inv_shiftrows_stream;

  typedef logic [7:0] block_t [16];

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] in_byte = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       out_last;

  inv_shiftrows_stream #(.DATA_W(8), .ZERO_IDLE(1'b1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_byte   (in_byte),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  int         n_vec = 0;
  int         n_err = 0;
  int         acc_cnt = 0;
  bit         last_seen = 1'b0;
  logic [7:0] src_q [$];
  logic [8:0] exp_q [$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // Encrypt-side ShiftRows written from the row-rotation definition.
  function automatic int sr_src(input int k);
    int c;
    int r;
    c = k / 4;
    r = k % 4;
    return 4 * ((c + r) % 4) + r;
  endfunction

  task automatic push_block(input block_t stim, input block_t exp);
    for (int k = 0; k < 16; k++) begin
      src_q.push_back(stim[k]);
      exp_q.push_back({(k == 15), exp[k]});
    end
  endtask

  // Schedules a random block through the encrypt model; the DUT must undo it.
  task automatic push_round_trip();
    block_t orig;
    block_t st;
    for (int k = 0; k < 16; k++) orig[k] = 8'($urandom_range(255));
    for (int k = 0; k < 16; k++) st[k] = orig[sr_src(k)];
    push_block(st, orig);
  endtask

  // One clock: drive at negedge, sample 1 time unit later, well away from posedge.
  task automatic cycle(input bit v_en, input bit r_en);
    logic [8:0] e;
    @(negedge clock);
    in_valid  = v_en && (src_q.size() > 0);
    in_byte   = (src_q.size() > 0) ? src_q[0] : 8'h00;
    out_ready = r_en;
    #1;
    last_seen = 1'b0;
    if (in_valid && in_ready) begin
      void'(src_q.pop_front());
      acc_cnt++;
    end
    if (out_valid) begin
      if (out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", {out_last, out_byte}, 9'h1ff);
        end else begin
          e = exp_q.pop_front();
          check("out_byte", out_byte, e[7:0]);
          check("out_last", out_last, e[8]);
          last_seen = out_last;
        end
      end
    end else begin
      check("idle_out", {out_last, out_byte}, 0);
    end
  endtask

  task automatic run(input int max_cycles, input int pv, input int pr);
    int n = 0;
    while ((src_q.size() > 0 || exp_q.size() > 0) && n < max_cycles) begin
      cycle($urandom_range(99) < pv, $urandom_range(99) < pr);
      n++;
    end
    check("run_drained", src_q.size() + exp_q.size(), 0);
    repeat (4) cycle(1'b0, 1'b1);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    src_q.delete();
    exp_q.delete();
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_byte", out_byte, 0);
    check("rst_in_ready", in_ready, 1);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    block_t inc;
    block_t lit;
    block_t inc10;
    block_t lit10;
    block_t fips_sr;
    block_t fips_sb;
    int     n;
    int     first_v;
    int     last_v;
    int     nv;

    lit     = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
    fips_sr = '{8'hd4, 8'hbf, 8'h5d, 8'h30, 8'he0, 8'hb4, 8'h52, 8'hae,
                8'hb8, 8'h41, 8'h11, 8'hf1, 8'h1e, 8'h27, 8'h98, 8'he5};
    fips_sb = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
    for (int k = 0; k < 16; k++) begin
      inc[k]   = 8'(k);
      inc10[k] = 8'(k + 16);
      lit10[k] = lit[k] + 8'h10;
    end

    do_reset();

    // Known-answer block, back to back.
    push_block(inc, lit);
    run(100, 100, 100);

    // FIPS-197 round-1 state, then 100 random round trips.
    push_block(fips_sr, fips_sb);
    for (int b = 0; b < 100; b++) push_round_trip();
    run(6000, 90, 90);

    // 50% gaps on both handshakes.
    push_block(inc, lit);
    push_block(inc, lit);
    for (int b = 0; b < 4; b++) push_round_trip();
    run(1000, 50, 50);

    // Backpressure: two banks fill, third block must wait.
    for (int b = 0; b < 3; b++) push_round_trip();
    acc_cnt = 0;
    repeat (40) cycle(1'b1, 1'b0);
    check("bp_accepted", acc_cnt, 32);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    n = 0;
    last_seen = 1'b0;
    while (!last_seen && n < 40) begin
      cycle(1'b1, 1'b1);
      n++;
    end
    check("bp_last_seen", last_seen, 1);
    check("bp_in_ready_at_last", in_ready, 0);
    cycle(1'b1, 1'b1);
    check("bp_in_ready_after", in_ready, 1);
    check("bp_accept_resumed", acc_cnt, 33);
    run(300, 100, 100);

    // Reset with one full bank and 9 bytes of a partial block.
    push_round_trip();
    exp_q.delete();
    for (int k = 0; k < 9; k++) src_q.push_back(8'($urandom_range(255)));
    acc_cnt = 0;
    repeat (25) cycle(1'b1, 1'b0);
    check("mid_accepted", acc_cnt, 25);
    do_reset();
    push_block(inc10, lit10);
    run(100, 100, 100);

    // Steady state: 8 blocks, no bubbles.
    for (int b = 0; b < 8; b++) push_round_trip();
    first_v = -1;
    last_v  = -1;
    nv      = 0;
    for (int i = 0; i < 200; i++) begin
      cycle(1'b1, 1'b1);
      if (out_valid) begin
        if (first_v < 0) first_v = i;
        last_v = i;
        nv++;
      end
    end
    check("ss_first_valid", first_v, 16);
    check("ss_last_valid", last_v, 143);
    check("ss_valid_count", nv, 128);
    check("ss_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
